// File: rtl/systolic_ctrl.sv
// Sequencer for a 3x3 8-bit systolic array: loads an operand pair, clears and feeds the array,
// waits out the drain latency, then streams the nine 16-bit results over a valid/ready port.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | in_ready high, waiting for an operand pair
// CLEAR   | array accumulators held in reset for one cycle
// FEED    | three cycles driving column k of A and row k of B
// DRAIN   | zeros on the array edge while the last products settle
// CAPTURE | snapshot of the packed array result
// STREAM  | nine result beats, idx 0..8, honouring res_ready
module systolic_ctrl #(
   parameter int DRAIN_CYCLES = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [71:0]   in_a,
   input  logic [71:0]   in_b,
   output logic [7:0]    a11,
   output logic [7:0]    a21,
   output logic [7:0]    a31,
   output logic [7:0]    b11,
   output logic [7:0]    b12,
   output logic [7:0]    b13,
   output logic          arr_rst_n,
   input  logic [143:0]  arr_c,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [15:0]   res_data,
   output logic [3:0]    res_idx,
   output logic          res_last,
   output logic          busy
);

   localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_DRAIN,
      S_CAPTURE,
      S_STREAM
   } state_t;

   state_t          state, state_nxt;
   logic [1:0]      k, k_nxt;
   logic [CW-1:0]   drain_cnt, drain_cnt_nxt;
   logic [3:0]      idx, idx_nxt;
   logic            load, capture;

   logic [71:0]     a_op, b_op;
   logic [143:0]    result;
   logic [7:0]      a_el [3][3];
   logic [7:0]      b_el [3][3];
   logic [15:0]     c_el [9];

   logic            in_ready_nxt, busy_nxt, arr_rst_n_nxt;
   logic [7:0]      a11_nxt, a21_nxt, a31_nxt, b11_nxt, b12_nxt, b13_nxt;
   logic            res_valid_nxt, res_last_nxt;
   logic [15:0]     res_data_nxt;
   logic [3:0]      res_idx_nxt;
   logic            feed, stream;

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            a_el[i][j] = a_op[8*(3*i+j) +: 8];
            b_el[i][j] = b_op[8*(3*i+j) +: 8];
         end
      end
   end

   // In CAPTURE the first beat is taken straight from arr_c, since result
   // is only written on the same edge.
   always_comb begin
      for (int e = 0; e < 9; e++) begin
         c_el[e] = (state == S_CAPTURE) ? arr_c[16*e +: 16] : result[16*e +: 16];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      k_nxt         = k;
      drain_cnt_nxt = drain_cnt;
      idx_nxt       = idx;
      load          = 1'b0;
      capture       = 1'b0;
      case (state)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               load      = 1'b1;
               state_nxt = S_CLEAR;
            end
         end
         S_CLEAR: begin
            state_nxt = S_FEED;
            k_nxt     = 2'd0;
         end
         S_FEED: begin
            if (k == 2'd2) begin
               state_nxt     = S_DRAIN;
               drain_cnt_nxt = CW'(DRAIN_CYCLES - 1);
            end else begin
               k_nxt = k + 2'd1;
            end
         end
         S_DRAIN: begin
            if (drain_cnt == '0) state_nxt = S_CAPTURE;
            else                 drain_cnt_nxt = drain_cnt - CW'(1);
         end
         S_CAPTURE: begin
            capture   = 1'b1;
            state_nxt = S_STREAM;
            idx_nxt   = 4'd0;
         end
         S_STREAM: begin
            if (res_ready) begin
               if (idx == 4'd8) state_nxt = S_IDLE;
               else             idx_nxt   = idx + 4'd1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Every output is registered from the next-state view so it lines up with the state register.
   always_comb begin
      feed          = (state_nxt == S_FEED);
      stream        = (state_nxt == S_STREAM);
      in_ready_nxt  = (state_nxt == S_IDLE);
      busy_nxt      = (state_nxt != S_IDLE);
      arr_rst_n_nxt = (state_nxt != S_CLEAR);
      a11_nxt       = 8'd0;
      a21_nxt       = 8'd0;
      a31_nxt       = 8'd0;
      b11_nxt       = 8'd0;
      b12_nxt       = 8'd0;
      b13_nxt       = 8'd0;
      res_valid_nxt = stream;
      res_idx_nxt   = 4'd0;
      res_data_nxt  = 16'd0;
      res_last_nxt  = 1'b0;
      if (feed) begin
         a11_nxt = a_el[0][k_nxt];
         a21_nxt = a_el[1][k_nxt];
         a31_nxt = a_el[2][k_nxt];
         b11_nxt = b_el[k_nxt][0];
         b12_nxt = b_el[k_nxt][1];
         b13_nxt = b_el[k_nxt][2];
      end
      if (stream) begin
         res_idx_nxt  = idx_nxt;
         res_data_nxt = c_el[idx_nxt];
         res_last_nxt = (idx_nxt == 4'd8);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         k         <= 2'd0;
         drain_cnt <= '0;
         idx       <= 4'd0;
         a_op      <= '0;
         b_op      <= '0;
         result    <= '0;
      end else begin
         k         <= k_nxt;
         drain_cnt <= drain_cnt_nxt;
         idx       <= idx_nxt;
         if (load) begin
            a_op <= in_a;
            b_op <= in_b;
         end
         if (capture) result <= arr_c;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_ready  <= 1'b0;
         busy      <= 1'b0;
         arr_rst_n <= 1'b0;
         a11       <= 8'd0;
         a21       <= 8'd0;
         a31       <= 8'd0;
         b11       <= 8'd0;
         b12       <= 8'd0;
         b13       <= 8'd0;
         res_valid <= 1'b0;
         res_data  <= 16'd0;
         res_idx   <= 4'd0;
         res_last  <= 1'b0;
      end else begin
         in_ready  <= in_ready_nxt;
         busy      <= busy_nxt;
         arr_rst_n <= arr_rst_n_nxt;
         a11       <= a11_nxt;
         a21       <= a21_nxt;
         a31       <= a31_nxt;
         b11       <= b11_nxt;
         b12       <= b12_nxt;
         b13       <= b13_nxt;
         res_valid <= res_valid_nxt;
         res_data  <= res_data_nxt;
         res_idx   <= res_idx_nxt;
         res_last  <= res_last_nxt;
      end
   end

endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
Controller for the 3x3 8-bit systolic array. It accepts a pair of 3x3 operand matrices over a valid/ready load port. It clears the array accumulators and drives the unskewed operand columns and rows into the array edge; the array applies the row-2/3 and column-2/3 skew internally. After a programmable drain it captures the array's 144-bit packed result and streams the nine 16-bit C elements out over a valid/ready result port.

Parameters:
DRAIN_CYCLES, 6, cycles spent in DRAIN after the last FEED cycle before capturing arr_c; must be at least the array's last-operand-to-C33-update latency.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  controller can accept operands
in_a  in  72  matrix A, row-major, A[i][j] at bits 8*(3i+j)+:8
in_b  in  72  matrix B, same packing
a11, a21, a31  out  8 each  array row inputs
b11, b12, b13  out  8 each  array column inputs
arr_rst_n  out  1  registered active-low clear to the array rst pin
arr_c  in  144  array result, C[i][j] at bits 16*(3i+j)+:16
res_valid  out  1  result beat valid
res_ready  in  1  downstream accepts beat
res_data  out  16  result element
res_idx  out  4  element index 0..8 (3i+j)
res_last  out  1  high on the idx-8 beat
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values (rst low, asynchronous):
  - state=IDLE, all array data outputs 0, arr_rst_n=0 (array held cleared).
  - res_valid=0, res_data=0, res_idx=0, res_last=0, busy=0.
  - in_ready=0 while rst is low; in_ready=1 on the first cycle after release.
- All outputs are registered. arr_rst_n=1 in every state except CLEAR and reset.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch in_a/in_b into internal regs and go to CLEAR.
  - in_ready=0 in all other states; in_valid is ignored there and nothing is latched.
- CLEAR: 1 cycle. arr_rst_n=0, data outputs 0. Then go to FEED with k=0.
- FEED: 3 cycles, k=0,1,2.
  - a11=A[0][k], a21=A[1][k], a31=A[2][k].
  - b11=B[k][0], b12=B[k][1], b13=B[k][2].
  - After k=2, go to DRAIN.
- DRAIN: DRAIN_CYCLES cycles, counter counts down. All array data outputs are 0 so no further products accumulate. At count end go to CAPTURE.
- CAPTURE: 1 cycle. Latch arr_c into a 144-bit result register. Go to STREAM with idx=0.
- STREAM:
  - res_valid=1, res_data=result[16*idx+:16], res_idx=idx, res_last=(idx==8).
  - A beat transfers on res_valid&&res_ready; idx then increments.
  - res_data, res_idx and res_last must hold stable while res_valid&&!res_ready.
  - The idx-8 transfer returns the controller to IDLE with res_valid=0 on the next cycle.
- Latency with no backpressure:
  - Load handshake at edge T: CLEAR visible T+1; FEED T+2..T+4; DRAIN T+5..T+4+DRAIN_CYCLES; CAPTURE T+5+DRAIN_CYCLES.
  - First res_valid at T+6+DRAIN_CYCLES; last beat 8 cycles later.
  - in_ready returns 1 on the cycle after the last beat.
- Arithmetic: the controller performs none. Result values are whatever the array produced, including the 16-bit wrap of the array accumulators.
- Reset mid-operation:
  - Immediately returns to IDLE and drives all outputs to reset values.
  - Latched operands and the partial stream are discarded.
  - The array is cleared via arr_rst_n.
- No new load can overlap a stream; back-to-back operations are separated by the IDLE handshake cycle.

Test Plan:
- A=[[1,2,3],[4,5,6],[7,8,9]], B=identity, res_ready=1 -> beats idx0..8 = 1,2,3,4,5,6,7,8,9; res_last only on idx 8; first res_valid exactly T+12 with DRAIN_CYCLES=6.
- A and B all 0xFF -> every beat = 64003 (3*65025 mod 65536); a second op with A=identity, B=[[2,0,0],[0,2,0],[0,0,2]] -> diag 2, off-diag 0, proving CLEAR removes prior accumulation.
- res_ready toggling 1,0,0,1,... during STREAM -> data/idx stable while stalled, all 9 beats delivered once in order, no duplicates or drops.
- in_valid held high during FEED/DRAIN/STREAM with different operands -> in_ready=0, the later operands are not used; the next op loads only after return to IDLE.
- rst pulsed low during FEED k=1, then a fresh load of A=B=identity -> all outputs 0 and arr_rst_n=0 during reset; the following op returns the identity (1 at idx 0,4,8, else 0).
- Array-edge probe on one op: a11/a21/a31 = columns of A and b11/b12/b13 = rows of B on the three FEED cycles, zero in CLEAR and DRAIN; arr_rst_n low for exactly one cycle.
